ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and sequencer for the single-ported on-chip RAM. It lets two requesters share the RAM through a req/ack handshake: port A is the CPU memory bus, port B a secondary master such as a loader or debug port. It sits between both masters and the RAM's address, data_in, data_out and write_enable pins. It accounts for the RAM's registered read, which updates only on non-write cycles.

## Interface
Parameters:
- ADDR_WIDTH, 10, address width of both ports and the RAM.
- DATA_WIDTH, 8, data width of both ports and the RAM.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_req  input  1  port A access request; held high until a_ack.
- a_write  input  1  port A: 1 = write, 0 = read; stable while a_req is high.
- a_address  input  ADDR_WIDTH  port A address; stable while a_req is high.
- a_data_in  input  DATA_WIDTH  port A write data; stable while a_req is high.
- a_data_out  output  DATA_WIDTH  port A read data; valid when a_ack is high, held until the next port A read completes.
- a_ack  output  1  port A completion strobe, one cycle.
- b_req, b_write, b_address, b_data_in, b_data_out, b_ack: identical to the port A signals, for port B.
- ram_address  output  ADDR_WIDTH  to RAM address.
- ram_data_in  output  DATA_WIDTH  to RAM data_in.
- ram_write_enable  output  1  to RAM write_enable.
- ram_data_out  input  DATA_WIDTH  from RAM data_out, registered one cycle.
- busy  output  1  high in any state other than IDLE.
- grant_b  output  1  owner of the current or last transaction; 0 = A, 1 = B.

## Operation
- State machine states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise select a winner per the arbitration rule.
  - Latch the winner's address, data and write into internal registers; set grant_b; go to ISSUE.
- ISSUE:
  - ram_address and ram_data_in are driven from the latched registers.
  - ram_write_enable equals the latched write bit.
  - Go to CAPTURE.
- CAPTURE:
  - ram_write_enable is 0; ram_address is held.
  - On a read, ram_data_out is valid this cycle. Load it into the winner's data_out register at the closing edge.
  - Go to DONE.
- DONE:
  - The winner's ack is high.
  - All req inputs are ignored.
  - Go to IDLE.
- A write leaves the winner's data_out unchanged.
- The loser's req stays pending and is granted at the next IDLE.
- Arbitration default (macro absent): fixed priority, A wins whenever a_req is high.
- ram_address and ram_data_in hold their last values in IDLE and DONE. ram_write_enable is 1 only in ISSUE.
- Reset values: state IDLE; a_ack, b_ack, ram_write_enable, busy, grant_b all 0; a_data_out, b_data_out, ram_address, ram_data_in all 0.
- Reset mid-operation:
  - The transaction is aborted and no ack is issued.
  - ram_write_enable drops immediately. A write whose ISSUE cycle is cut by reset may not reach the RAM.
  - The requester must re-issue after reset.

## Timing
- A req sampled high in IDLE at edge 0 gives ISSUE in cycle 1, CAPTURE in cycle 2, and ack high in cycle 3.
- Latency is 3 cycles from the sampling edge to ack, for both reads and writes.
- Throughput is 1 access per 4 cycles.
- Back-to-back from one port: the requester updates its inputs in the cycle after ack, keeping req high. The new request is sampled in IDLE the next cycle.
- A req that rises during ISSUE, CAPTURE or DONE waits for the next IDLE.
- Simultaneous a_req and b_req in IDLE: exactly one grant; the other is served in the following transaction (ack 4 cycles later).
- ack is registered, never combinational from req, and never high on both ports in the same cycle.

## Configuration
- RAM_ARBITER_ROUND_ROBIN_EN:
  - Defined: round-robin arbitration. On contention in IDLE, the port not granted last wins. The "last grant" register resets to B, so A wins the first tie. With a single requester, that requester wins regardless of history.
  - Undefined: fixed priority to port A as described in Operation. Port B can be starved by continuous port A traffic.

## Test plan
- Single read: preload RAM[0x155]=0xA5. Pulse a_req, a_write=0, a_address=0x155 → a_ack high exactly 3 cycles after the sampling edge; a_data_out=0xA5; b_ack stays 0.
- Write then read: B writes 0x3C to 0x200, then reads 0x200 → ram_write_enable high for exactly one cycle with ram_address=0x200; b_data_out=0x3C; b_data_out unchanged after the write ack.
- Contention: a_req and b_req rise on the same edge, A reads 0x001 (0x11), B reads 0x002 (0x22) → A acked first with 0x11, B acked 4 cycles later with 0x22; acks never overlap.
- Continuous contention with both reqs held high for 8 transactions:
  - Without the macro: all grants go to A.
  - With RAM_ARBITER_ROUND_ROBIN_EN: grants alternate A, B, A, B…
- Reset in ISSUE of a write of 0x77 to 0x010 (RAM[0x010] was 0x00) → ram_write_enable falls immediately; no ack; busy=0; after release, a read of 0x010 completes normally.
- Idle check: no req for 20 cycles → busy=0, ram_write_enable=0, both acks 0 throughout.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port req/ack arbiter sequencing accesses to a single-ported RAM with a registered read.
// Optional macro RAM_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration; fixed priority to A otherwise.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [DATA_WIDTH-1:0] a_data_in,
    output logic [DATA_WIDTH-1:0] a_data_out,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [DATA_WIDTH-1:0] b_data_in,
    output logic [DATA_WIDTH-1:0] b_data_out,
    output logic                  b_ack,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy,
    output logic                  grant_b
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    write_reg;
    logic                    grant_b_reg;
    logic [DATA_WIDTH-1:0]   a_data_out_reg;
    logic [DATA_WIDTH-1:0]   b_data_out_reg;
    logic                    any_req;
    logic                    win_b;

    assign any_req = a_req | b_req;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    // Tracks the previous winner; starts at B so that A takes the first tie.
    logic last_b_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_b_reg <= 1'b1;
        end else if (state_reg == IDLE && any_req) begin
            last_b_reg <= win_b;
        end
    end

    assign win_b = b_req && (!a_req || !last_b_reg);
`else
    assign win_b = !a_req;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch and read-data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg       <= '0;
            data_reg       <= '0;
            write_reg      <= 1'b0;
            grant_b_reg    <= 1'b0;
            a_data_out_reg <= '0;
            b_data_out_reg <= '0;
        end else begin
            if (state_reg == IDLE && any_req) begin
                addr_reg    <= win_b ? b_address : a_address;
                data_reg    <= win_b ? b_data_in : a_data_in;
                write_reg   <= win_b ? b_write   : a_write;
                grant_b_reg <= win_b;
            end
            // The RAM's registered read is valid during CAPTURE only.
            if (state_reg == CAPTURE && !write_reg) begin
                if (grant_b_reg) begin
                    b_data_out_reg <= ram_data_out;
                end else begin
                    a_data_out_reg <= ram_data_out;
                end
            end
        end
    end

    // Outputs decode from registered state only, so acks never follow req combinationally.
    always_comb begin
        busy             = (state_reg != IDLE);
        ram_write_enable = (state_reg == ISSUE) && write_reg;
        a_ack            = (state_reg == DONE) && !grant_b_reg;
        b_ack            = (state_reg == DONE) && grant_b_reg;
    end

    assign ram_address = addr_reg;
    assign ram_data_in = data_reg;
    assign grant_b     = grant_b_reg;
    assign a_data_out  = a_data_out_reg;
    assign b_data_out  = b_data_out_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM (registered read on non-write cycles).
module tb_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_write, b_req, b_write;
    logic [AW-1:0] a_address, b_address;
    logic [DW-1:0] a_data_in, b_data_in, a_data_out, b_data_out;
    logic          a_ack, b_ack;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in, ram_data_out;
    logic          ram_write_enable, busy, grant_b;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] mem [1024];

    int total = 0;
    int bad = 0;
    int both_ack_cnt, we_cnt, a_ack_cnt, b_ack_cnt, busy_cnt;
    logic [AW-1:0] we_addr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_write_enable) begin
            mem[ram_address] <= ram_data_in;
        end else begin
            ram_data_out <= mem[ram_address];
        end
    end

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_write(a_write), .a_address(a_address), .a_data_in(a_data_in),
        .a_data_out(a_data_out), .a_ack(a_ack),
        .b_req(b_req), .b_write(b_write), .b_address(b_address), .b_data_in(b_data_in),
        .b_data_out(b_data_out), .b_ack(b_ack),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out),
        .busy(busy), .grant_b(grant_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        both_ack_cnt = 0; we_cnt = 0; a_ack_cnt = 0; b_ack_cnt = 0; busy_cnt = 0; we_addr = '0;
    endtask

    // One clock: advance past the edge, then sample every output of interest.
    task automatic step();
        @(posedge clk);
        #1;
        if (a_ack && b_ack) both_ack_cnt++;
        if (a_ack) a_ack_cnt++;
        if (b_ack) b_ack_cnt++;
        if (busy) busy_cnt++;
        if (ram_write_enable) begin
            we_cnt++;
            we_addr = ram_address;
        end
    endtask

    task automatic wait_ack(input bit port_b, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(port_b ? b_ack : a_ack) && n < 20);
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        pre_addr = addr;
        pre_data = data;
        pre_we = 1'b1;
        step();
        pre_we = 1'b0;
    endtask

    initial begin
        int n;
        logic [DW-1:0] prev;
        bit port;
        reset = 1'b1;
        a_req = 0; a_write = 0; a_address = '0; a_data_in = '0;
        b_req = 0; b_write = 0; b_address = '0; b_data_in = '0;
        pre_we = 0; pre_addr = '0; pre_data = '0;
        clear_mon();

        preload(10'h155, 8'hA5);
        preload(10'h001, 8'h11);
        preload(10'h002, 8'h22);
        preload(10'h010, 8'h00);
        preload(10'h200, 8'h00);
        step();

        // Reset values
        check("rst_a_ack", a_ack, 0);
        check("rst_b_ack", b_ack, 0);
        check("rst_we", ram_write_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_b", grant_b, 0);
        check("rst_a_data_out", a_data_out, 0);
        check("rst_b_data_out", b_data_out, 0);
        check("rst_ram_address", ram_address, 0);
        check("rst_ram_data_in", ram_data_in, 0);
        reset = 1'b0;
        step();

        // Single read from A
        clear_mon();
        a_req = 1; a_write = 0; a_address = 10'h155;
        wait_ack(0, n);
        check("rd_latency", n, 3);
        check("rd_a_data_out", a_data_out, 8'hA5);
        check("rd_grant_b", grant_b, 0);
        a_req = 0;
        step();
        check("rd_b_ack_cnt", b_ack_cnt, 0);
        check("rd_a_ack_cnt", a_ack_cnt, 1);

        // B write then back-to-back read
        clear_mon();
        prev = b_data_out;
        b_req = 1; b_write = 1; b_address = 10'h200; b_data_in = 8'h3C;
        wait_ack(1, n);
        check("wr_latency", n, 3);
        check("wr_we_cycles", we_cnt, 1);
        check("wr_we_addr", we_addr, 10'h200);
        check("wr_b_data_unchanged", b_data_out, prev);
        check("wr_grant_b", grant_b, 1);
        b_write = 0; b_data_in = 8'h00;
        wait_ack(1, n);
        check("b2b_latency", n, 4);
        check("b2b_b_data_out", b_data_out, 8'h3C);
        b_req = 0;
        step();

        // Simultaneous requests
        clear_mon();
        a_req = 1; a_write = 0; a_address = 10'h001;
        b_req = 1; b_write = 0; b_address = 10'h002;
        wait_ack(0, n);
        check("cont_a_latency", n, 3);
        check("cont_a_data_out", a_data_out, 8'h11);
        a_req = 0;
        wait_ack(1, n);
        check("cont_b_gap", n, 4);
        check("cont_b_data_out", b_data_out, 8'h22);
        b_req = 0;
        step();
        check("cont_ack_overlap", both_ack_cnt, 0);

        // Continuous contention for 8 transactions; last winner was B
        clear_mon();
        a_req = 1; a_address = 10'h001;
        b_req = 1; b_address = 10'h002;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!(a_ack || b_ack) && n < 20);
            port = b_ack;
            check($sformatf("hold_grant_%0d", i), port, RR ? (i % 2) : 0);
            if (i == 7) begin
                a_req = 0;
                b_req = 0;
            end
        end
        step();
        check("hold_ack_overlap", both_ack_cnt, 0);

        // Reset during the ISSUE cycle of a write
        clear_mon();
        a_req = 1; a_write = 1; a_address = 10'h010; a_data_in = 8'h77;
        n = 0;
        do begin
            step();
            n++;
        end while (!ram_write_enable && n < 20);
        check("rstw_issue_seen", ram_write_enable, 1);
        reset = 1'b1;
        #1;
        check("rstw_we_drop", ram_write_enable, 0);
        check("rstw_busy", busy, 0);
        a_req = 0; a_write = 0;
        clear_mon();
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check("rstw_no_ack", a_ack_cnt + b_ack_cnt, 0);
        a_req = 1; a_address = 10'h010;
        wait_ack(0, n);
        check("rstw_read_latency", n, 3);
        check("rstw_read_data", a_data_out, 8'h00);
        a_req = 0;
        step();

        // Idle for 20 cycles
        clear_mon();
        for (int i = 0; i < 20; i++) step();
        check("idle_busy_cycles", busy_cnt, 0);
        check("idle_we_cycles", we_cnt, 0);
        check("idle_ack_cycles", a_ack_cnt + b_ack_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
